// File: rtl/aes_state_loader_if.sv
// Word-stream and block handshake bundle for the AES state loader.
interface aes_state_loader_if #(
  parameter int NW = 4
);
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;
  logic        blk_valid;
  logic        blk_ready;
  logic        load_en;
  logic [31:0] state_o [NW];

  modport master (
    output word_valid, word_data, blk_ready,
    input  word_ready, blk_valid, load_en, state_o
  );

  modport slave (
    input  word_valid, word_data, blk_ready,
    output word_ready, blk_valid, load_en, state_o
  );
endinterface

// File: rtl/aes_state_loader.sv
// AES input staging: packs 32-bit words into a double-buffered state block.
// Optional macro AES_LOADER_BSWAP_EN byte-reverses each accepted word.
module aes_state_loader #(
  parameter int NUM_WORDS = 4,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             flush,
  aes_state_loader_if.slave bus,
  output logic [CNT_W-1:0] blk_count,
  output logic             busy
);

  localparam int IW = $clog2(NUM_WORDS);
  localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

  typedef enum logic {FILL, FULL} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [31:0]      asm_q [NUM_WORDS];
  logic [31:0]      asm_d [NUM_WORDS];
  logic [31:0]      out_q [NUM_WORDS];
  logic [31:0]      out_d [NUM_WORDS];
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        w_hs;
  logic        slot_free;
  logic [31:0] wdat;

`ifdef AES_LOADER_BSWAP_EN
  assign wdat = {bus.word_data[7:0],   bus.word_data[15:8],
                 bus.word_data[23:16], bus.word_data[31:24]};
`else
  assign wdat = bus.word_data;
`endif

  // Ready is forced low while reset is held, independent of the clock.
  assign bus.word_ready = CLR_N && (state_q == FILL) && !flush;
  assign bus.load_en    = vld_q && bus.blk_ready;
  assign bus.blk_valid  = vld_q;
  assign bus.state_o    = out_q;
  assign blk_count      = cnt_q;
  assign busy = vld_q || (state_q == FULL) || (idx_q != '0);

  assign w_hs      = bus.word_valid && bus.word_ready;
  assign slot_free = !vld_q || bus.load_en;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    out_d   = out_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;

    if (bus.load_en) begin
      vld_d = 1'b0;
      cnt_d = cnt_q + 1'b1;
    end

    unique case (state_q)
      FILL: begin
        if (flush) begin
          idx_d = '0;
        end else if (w_hs) begin
          asm_d[idx_q] = wdat;
          if (idx_q == LAST) begin
            idx_d = '0;
            if (slot_free) begin
              for (int i = 0; i < NUM_WORDS; i++)
                out_d[i] = (i == NUM_WORDS - 1) ? wdat : asm_q[i];
              vld_d = 1'b1;
            end else begin
              state_d = FULL;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      FULL: begin
        // Flush drops the parked block; an output handshake still completes.
        if (flush) begin
          state_d = FILL;
        end else if (bus.load_en) begin
          out_d   = asm_q;
          vld_d   = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= FILL;
      idx_q   <= '0;
      asm_q   <= '{default: '0};
      out_q   <= '{default: '0};
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/aes_state_loader.md
Name: aes_state_loader

Overview:
- Input staging stage of the cipher unit. Sits directly upstream of the 128-bit state register.
- Accepts plaintext as a stream of 32-bit words on a valid/ready handshake and assembles four words into one state block.
- Presents the block as state_o[3:0] with a block-level valid/ready handshake.
- Drives load_en, which connects straight to the state register's write enable.
- Double-buffered: one assembly buffer plus one output holding register, so the next block can fill while the current one waits.

Parameters:
- NUM_WORDS, 4, words per state block; fixed at 4 for AES-128 state.
- CNT_W, 16, width of the delivered-block counter.

Ports:
- CLK  in  1  rising-edge clock.
- CLR_N  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; discards a partially assembled block.
- word_valid  in  1  input word valid.
- word_ready  out  1  loader can accept a word this cycle.
- word_data  in  32  input word; the first word of a block maps to state_o[0].
- blk_valid  out  1  state_o holds a complete block.
- blk_ready  in  1  downstream accepts the block.
- state_o  out  32 x [3:0]  assembled block, unpacked array of four 32-bit words.
- load_en  out  1  equals blk_valid & blk_ready (combinational); write enable for the state register.
- blk_count  out  CNT_W  number of blocks delivered; wraps modulo 2^CNT_W.
- busy  out  1  high when the assembly buffer holds at least one word or blk_valid is high.

Behaviour:
- Reset (CLR_N low, asynchronous): state returns to FILL with word index 0; assembly buffer cleared; all four state_o words = 0; blk_valid = 0; blk_count = 0; word_ready = 0 while CLR_N is low.
- A reset mid-block discards all partial data.
- Assembly FSM, state FILL (index 0..3):
  - word_ready = !flush.
  - On a word handshake, the word is written to assembly slot [index] and index increments.
  - On the handshake at index 3:
    - If the output slot is free (blk_valid == 0, or load_en is high this cycle), the assembled block (including the current word) moves to state_o at the same edge, blk_valid = 1 next cycle, and index returns to 0.
    - Otherwise the FSM goes to FULL.
- Assembly FSM, state FULL:
  - word_ready = 0.
  - When the output slot frees (load_en high), the assembly buffer moves to state_o at that edge; blk_valid stays 1; next state is FILL with index 0.
- Output register:
  - state_o and blk_valid stay stable while blk_valid && !blk_ready.
  - blk_valid falls after a handshake unless a new block loads at the same edge.
- Latency: last word accepted at edge N gives blk_valid high after edge N, provided the slot is free. Sustained throughput is 1 word/cycle, with no bubble between blocks when blk_ready is held high.
- flush:
  - In FILL: index returns to 0 and the partial block is dropped. Any word presented in that cycle is not accepted (word_ready = 0).
  - In FULL: the assembled block is dropped and the next state is FILL.
  - flush never affects state_o, blk_valid or blk_count.
  - flush and load_en in the same cycle: the output handshake completes normally.
- blk_count increments by 1 on each load_en cycle; 0xFFFF wraps to 0x0000.
- word_data is ignored when word_valid = 0. No X propagates into state_o.

Optional Feature:
- Macro: AES_LOADER_BSWAP_EN.
- Defined: each accepted word is byte-reversed before storage, i.e. {b0,b1,b2,b3} is stored as {b3,b2,b1,b0}, for little-endian host streams.
- Undefined: words are stored unmodified.
- Ports, timing and counter behaviour are identical in both builds.

Test Plan:
- Single block, blk_ready = 1: send 00112233, 44556677, 8899AABB, CCDDEEFF on consecutive cycles -> blk_valid and load_en high exactly one cycle after the 4th word; state_o[0..3] equal the words in order; blk_count = 1.
- Back-pressure: blk_ready = 0, stream 8 words -> first block held stable; FSM in FULL and word_ready = 0 after word 8. Raise blk_ready -> two consecutive load_en pulses delivering block 1 then block 2; no word lost; blk_count = 2.
- Flush: send 2 words, assert flush one cycle with word_valid high -> that word is not accepted. Then send 4 new words A0000000..A0000003 -> a single block of the new words; blk_count increments by 1.
- Reset mid-operation: 3 words accepted with one block pending in the output register; pulse CLR_N low asynchronously between clock edges -> blk_valid, state_o, blk_count and busy are 0 immediately. The next 4 words form a clean block.
- Counter wrap: preload via 65535 block deliveries (or force) -> the next delivery makes blk_count 0x0000.
- AES_LOADER_BSWAP_EN defined: word 00112233 -> state_o[0] = 33221100. Undefined: state_o[0] = 00112233.
